// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - two-requester round-robin scheduler in front of a shared ALU
module alu_req_scheduler #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  input  logic [3:0]       REQ0_FUN,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [3:0]       REQ1_FUN,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  output logic             REQ1_READY,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_FUN,
  output logic             ALU_EN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ALU_OUT_VALID,
  output logic             RSP_VALID,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic [3:0]       RSP_CLASS,
  output logic             RSP_TIMEOUT
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic [7:0]       r_cnt;
  logic [3:0]       r_fun;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic             r_rsp_id;
  logic [3:0]       r_rsp_class;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_to;

  logic             w_any;
  logic             w_grant_id;
  logic             w_hs;
  logic             w_res;
  logic             w_tmo;
  logic [3:0]       w_class;

  assign w_any = REQ0_VALID | REQ1_VALID;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    w_grant_id = REQ1_VALID;
    if (REQ0_VALID && REQ1_VALID) w_grant_id = ~r_last;
  end

  assign w_hs       = (r_state == S_IDLE) && !RST && w_any;
  assign REQ0_READY = w_hs && REQ0_VALID && !w_grant_id;
  assign REQ1_READY = w_hs && REQ1_VALID && w_grant_id;

  // A result arriving on the final WAIT cycle takes priority over the timeout.
  assign w_res = (r_state == S_WAIT) && ALU_OUT_VALID;
  assign w_tmo = (r_state == S_WAIT) && !ALU_OUT_VALID && (r_cnt == TO_LAST);

  always_comb begin
    w_class = 4'b1000;
    case (r_fun[3:2])
      2'b00:   w_class = 4'b1000;
      2'b01:   w_class = 4'b0100;
      2'b10:   w_class = 4'b0010;
      default: w_class = 4'b0001;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_res || w_tmo) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_cnt       <= 8'd0;
      r_fun       <= 4'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_class <= 4'd0;
      r_rsp_data  <= '0;
      r_rsp_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_fun  <= w_grant_id ? REQ1_FUN : REQ0_FUN;
        r_a    <= w_grant_id ? REQ1_A : REQ0_A;
        r_b    <= w_grant_id ? REQ1_B : REQ0_B;
        r_id   <= w_grant_id;
        r_last <= w_grant_id;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= 8'd0;
      end else if ((r_state == S_WAIT) && !ALU_OUT_VALID) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_res) begin
        r_rsp_data <= ALU_OUT;
        r_rsp_to   <= 1'b0;
      end else if (w_tmo) begin
        r_rsp_data <= '0;
        r_rsp_to   <= 1'b1;
      end
      if (w_res || w_tmo) begin
        r_rsp_id    <= r_id;
        r_rsp_class <= w_class;
      end
    end
  end

  assign ALU_A       = r_a;
  assign ALU_B       = r_b;
  assign ALU_FUN     = r_fun;
  assign ALU_EN      = (r_state == S_ISSUE);
  assign RSP_VALID   = (r_state == S_RESP);
  assign RSP_ID      = r_rsp_id;
  assign RSP_DATA    = r_rsp_data;
  assign RSP_CLASS   = r_rsp_class;
  assign RSP_TIMEOUT = r_rsp_to;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - directed self-checking bench for alu_req_scheduler
module tb_alu_req_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VALID, REQ1_VALID;
  logic [3:0]  REQ0_FUN, REQ1_FUN;
  logic [15:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic        REQ0_READY, REQ1_READY;
  logic [15:0] ALU_A, ALU_B, ALU_OUT, RSP_DATA;
  logic [3:0]  ALU_FUN, RSP_CLASS;
  logic        ALU_EN, ALU_OUT_VALID, RSP_VALID, RSP_ID, RSP_TIMEOUT;

  int n_checks = 0;
  int n_fail   = 0;

  alu_req_scheduler #(.WIDTH(16), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_FUN(REQ0_FUN), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_FUN(REQ1_FUN), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .REQ1_READY(REQ1_READY),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
    .RSP_CLASS(RSP_CLASS), .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!RSP_VALID && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready0"}, REQ0_READY, 0);
    check({tag, "_ready1"}, REQ1_READY, 0);
    check({tag, "_alu_a"}, ALU_A, 0);
    check({tag, "_alu_b"}, ALU_B, 0);
    check({tag, "_alu_fun"}, ALU_FUN, 0);
    check({tag, "_alu_en"}, ALU_EN, 0);
    check({tag, "_rsp_valid"}, RSP_VALID, 0);
    check({tag, "_rsp_id"}, RSP_ID, 0);
    check({tag, "_rsp_data"}, RSP_DATA, 0);
    check({tag, "_rsp_class"}, RSP_CLASS, 0);
    check({tag, "_rsp_to"}, RSP_TIMEOUT, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int en_t[4];
    int en_a[4];
    int rid[4];
    int rcls[4];
    int ne, nr;

    RST = 1'b1;
    REQ0_VALID = 1'b1; REQ0_FUN = 4'h0; REQ0_A = 16'h0; REQ0_B = 16'h0;
    REQ1_VALID = 1'b1; REQ1_FUN = 4'h0; REQ1_A = 16'h0; REQ1_B = 16'h0;
    ALU_OUT = 16'h0; ALU_OUT_VALID = 1'b0;
    tick();
    tick();
    check_all_zero("rst0");
    REQ1_VALID = 1'b0;
    RST = 1'b0;

    // Single command with a result one cycle after the start strobe
    REQ0_VALID = 1'b1; REQ0_FUN = 4'b0000; REQ0_A = 16'h0003; REQ0_B = 16'h0004;
    #1;
    check("t1_ready0", REQ0_READY, 1);
    check("t1_ready1", REQ1_READY, 0);
    tick();
    REQ0_VALID = 1'b0;
    check("t1_en", ALU_EN, 1);
    check("t1_alu_a", ALU_A, 16'h0003);
    check("t1_alu_b", ALU_B, 16'h0004);
    check("t1_alu_fun", ALU_FUN, 4'b0000);
    check("t1_ready0_issue", REQ0_READY, 0);
    ALU_OUT = 16'hBEEF; ALU_OUT_VALID = 1'b1;
    tick();
    check("t1_en_off", ALU_EN, 0);
    check("t1_no_rsp_wait", RSP_VALID, 0);
    ALU_OUT = 16'h0007;
    tick();
    ALU_OUT_VALID = 1'b0;
    check("t1_rsp_valid", RSP_VALID, 1);
    check("t1_rsp_data", RSP_DATA, 16'h0007);
    check("t1_rsp_id", RSP_ID, 0);
    check("t1_rsp_class", RSP_CLASS, 4'b1000);
    check("t1_rsp_to", RSP_TIMEOUT, 0);
    tick();
    check("t1_rsp_pulse", RSP_VALID, 0);
    check("t1_data_hold", RSP_DATA, 16'h0007);
    check("t1_alu_a_hold", ALU_A, 16'h0003);

    // Result strobe while idle is ignored
    ALU_OUT = 16'h1234; ALU_OUT_VALID = 1'b1;
    tick();
    ALU_OUT_VALID = 1'b0;
    tick();
    check("idle_pulse_rsp", RSP_VALID, 0);
    check("idle_pulse_data", RSP_DATA, 16'h0007);

    // Continuous contention after reset: grants alternate starting with 0
    RST = 1'b1;
    tick();
    RST = 1'b0;
    REQ0_VALID = 1'b1; REQ0_FUN = 4'b0100; REQ0_A = 16'h0011; REQ0_B = 16'h0012;
    REQ1_VALID = 1'b1; REQ1_FUN = 4'b1000; REQ1_A = 16'h0022; REQ1_B = 16'h0023;
    ALU_OUT = 16'h0055; ALU_OUT_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en_t[i] = -100; en_a[i] = -1; rid[i] = -1; rcls[i] = -1;
    end
    ne = 0; nr = 0;
    for (int c = 0; c < 17; c++) begin
      tick();
      if (ALU_EN && ne < 4) begin
        en_t[ne] = c; en_a[ne] = int'(ALU_A); ne++;
      end
      if (RSP_VALID && nr < 4) begin
        rid[nr] = int'(RSP_ID); rcls[nr] = int'(RSP_CLASS); nr++;
      end
    end
    check("t2_en_count", ne, 4);
    check("t2_rsp_count", nr, 4);
    check("t2_first_en", en_t[0], 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_grant%0d", i), rid[i], i % 2);
      check($sformatf("t2_class%0d", i), rcls[i], (i % 2 == 1) ? 4'b0010 : 4'b0100);
      check($sformatf("t2_alu_a%0d", i), en_a[i], (i % 2 == 1) ? 16'h0022 : 16'h0011);
      if (i > 0) check($sformatf("t2_gap%0d", i), en_t[i] - en_t[i-1], 4);
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    tick(); tick(); tick();
    ALU_OUT_VALID = 1'b0;
    check("t2_drain_idle", RSP_VALID, 0);

    // Timeout: no result ever arrives
    REQ1_VALID = 1'b1; REQ1_FUN = 4'b1101; REQ1_A = 16'h0005; REQ1_B = 16'h0006;
    #1;
    check("t3_ready1", REQ1_READY, 1);
    check("t3_ready0", REQ0_READY, 0);
    tick();
    REQ1_VALID = 1'b0;
    ALU_OUT = 16'hAAAA; ALU_OUT_VALID = 1'b1;
    tick();
    ALU_OUT_VALID = 1'b0;
    wait_rsp(20, n);
    check("t3_latency", 2 + n, 10);
    check("t3_rsp_valid", RSP_VALID, 1);
    check("t3_rsp_data", RSP_DATA, 16'h0000);
    check("t3_rsp_to", RSP_TIMEOUT, 1);
    check("t3_rsp_id", RSP_ID, 1);
    check("t3_rsp_class", RSP_CLASS, 4'b0001);
    tick();
    check("t3_rsp_pulse", RSP_VALID, 0);
    REQ0_VALID = 1'b1; REQ0_FUN = 4'b0101; REQ0_A = 16'h0009; REQ0_B = 16'h0009;
    #1;
    check("t3_back_idle", REQ0_READY, 1);

    // Result on the last WAIT cycle wins over the timeout
    tick();
    REQ0_VALID = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("t4_no_early_rsp", RSP_VALID, 0);
    ALU_OUT = 16'h00FF; ALU_OUT_VALID = 1'b1;
    tick();
    ALU_OUT_VALID = 1'b0;
    check("t4_rsp_valid", RSP_VALID, 1);
    check("t4_rsp_data", RSP_DATA, 16'h00FF);
    check("t4_rsp_to", RSP_TIMEOUT, 0);
    check("t4_rsp_id", RSP_ID, 0);
    check("t4_rsp_class", RSP_CLASS, 4'b0100);
    tick();

    // Reset in WAIT aborts the operation; arbitration restarts with requester 0
    REQ1_VALID = 1'b1; REQ1_FUN = 4'b0011; REQ1_A = 16'h0077; REQ1_B = 16'h0088;
    tick();
    REQ1_VALID = 1'b0;
    tick();
    tick();
    #2;
    RST = 1'b1;
    REQ0_VALID = 1'b1; REQ0_FUN = 4'b0001; REQ0_A = 16'h0101; REQ0_B = 16'h0202;
    REQ1_VALID = 1'b1;
    #1;
    check_all_zero("t5_rst");
    tick();
    check("t5_rst_rsp1", RSP_VALID, 0);
    tick();
    check("t5_rst_rsp2", RSP_VALID, 0);
    RST = 1'b0;
    #1;
    check("t5_ready0", REQ0_READY, 1);
    check("t5_ready1", REQ1_READY, 0);
    tick();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    check("t5_alu_a", ALU_A, 16'h0101);
    check("t5_alu_en", ALU_EN, 1);
    ALU_OUT = 16'h0303; ALU_OUT_VALID = 1'b1;
    tick();
    tick();
    ALU_OUT_VALID = 1'b0;
    check("t5_rsp_valid", RSP_VALID, 1);
    check("t5_rsp_id", RSP_ID, 0);
    check("t5_rsp_data", RSP_DATA, 16'h0303);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
ALU_REQ_SCHEDULER -- requirements
Module: alu_req_scheduler

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width.
REQ-002 Parameter TIMEOUT, default 8: maximum WAIT cycles for an ALU result; legal range 1..255.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 REQ0_VALID  input  1  requester 0 has a command.
REQ-006 REQ0_FUN  input  4  requester 0 ALU function code.
REQ-007 REQ0_A, REQ0_B  input  WIDTH each  requester 0 operands.
REQ-008 REQ0_READY  output  1  requester 0 command accepted this cycle when also VALID.
REQ-009 REQ1_VALID, REQ1_FUN, REQ1_A, REQ1_B, REQ1_READY: same as REQ-005..REQ-008 for requester 1.
REQ-010 ALU_A, ALU_B  output  WIDTH each  operands to the shared ALU.
REQ-011 ALU_FUN  output  4  function code to the ALU.
REQ-012 ALU_EN  output  1  one-cycle start strobe to the ALU.
REQ-013 ALU_OUT  input  WIDTH  ALU result.
REQ-014 ALU_OUT_VALID  input  1  ALU result valid.
REQ-015 RSP_VALID  output  1  one-cycle response strobe.
REQ-016 RSP_ID  output  1  requester index of the response.
REQ-017 RSP_DATA  output  WIDTH  result, or 0 on timeout.
REQ-018 RSP_CLASS  output  4  one-hot {Arith, Logic, CMP, Shift} decoded from FUN[3:2]: 00->1000, 01->0100, 10->0010, 11->0001.
REQ-019 RSP_TIMEOUT  output  1  response produced by timeout.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with exactly one active state.
REQ-021 In IDLE, READY SHALL be driven combinationally high for at most one requester, the granted one; READY is 0 in all other states.
REQ-022 Grant: if only one VALID, grant that requester; if both VALID, grant the requester not granted last (round-robin).
REQ-023 The last-granted pointer SHALL reset to 1, so that requester 0 wins the first contention.
REQ-024 On a VALID&&READY handshake, FUN, A, B and ID SHALL be captured and the FSM SHALL go to ISSUE; with no VALID it SHALL stay in IDLE.
REQ-025 ISSUE SHALL last exactly 1 cycle, with ALU_EN=1 and ALU_A, ALU_B, ALU_FUN equal to the captured values; the next state is WAIT.
REQ-026 ALU_A, ALU_B and ALU_FUN SHALL hold the captured values in every state until the next handshake; ALU_EN SHALL be 0 outside ISSUE.
REQ-027 ALU_OUT_VALID SHALL be ignored outside WAIT.
REQ-028 WAIT exit on result: on the first WAIT cycle with ALU_OUT_VALID=1, capture ALU_OUT to RSP_DATA, clear RSP_TIMEOUT, and go to RESP.
REQ-029 WAIT cycle counter: it SHALL clear on entry to WAIT and increment each WAIT cycle without ALU_OUT_VALID.
REQ-030 WAIT exit on timeout: when the counter reaches TIMEOUT, RSP_DATA=0 and RSP_TIMEOUT=1, and the FSM SHALL go to RESP.
REQ-031 If ALU_OUT_VALID=1 in the same cycle the timeout is reached, the result SHALL win (the REQ-028 path).
REQ-032 RESP SHALL last exactly 1 cycle with RSP_VALID=1, then return to IDLE.
REQ-033 There SHALL be no response backpressure.
REQ-034 RSP_ID and RSP_CLASS SHALL update from the captured command on entry to RESP.
REQ-035 RSP_DATA, RSP_ID, RSP_CLASS and RSP_TIMEOUT SHALL hold between responses.
REQ-036 Latency: handshake cycle N, ALU_EN at N+1, result valid at N+2, RSP_VALID at N+3; the minimum issue interval is 4 cycles.
REQ-037 A requester deasserting VALID without a handshake SHALL have no effect; commands are never dropped after a handshake except by RST.

Reset
REQ-038 While RST=1, the FSM SHALL be in IDLE, the counter 0, and the last-granted pointer 1.
REQ-039 While RST=1, ALU_A, ALU_B, ALU_FUN, ALU_EN, RSP_* and READY SHALL all be 0.
REQ-040 RST asserted in ISSUE, WAIT or RESP SHALL abort the operation immediately, with no RSP_VALID.
REQ-041 After reset release, arbitration SHALL resume in IDLE on the next edge.

Verification
REQ-042 REQ0 FUN=0000, A=0x0003, B=0x0004; ALU returns 0x0007 one cycle after EN -> RSP_VALID 3 cycles after the handshake, RSP_ID=0, RSP_DATA=0x0007, RSP_CLASS=1000, RSP_TIMEOUT=0.
REQ-043 Both VALID held continuously with FUN=0100 and FUN=1000 -> grants 0,1,0,1; RSP_CLASS alternates 0100 and 0010; ALU_EN pulses every 4 cycles.
REQ-044 ALU_OUT_VALID never asserted, TIMEOUT=8 -> RSP_VALID after 8 WAIT cycles, RSP_DATA=0x0000, RSP_TIMEOUT=1, FSM back in IDLE.
REQ-045 ALU_OUT_VALID first asserted in the 8th WAIT cycle with ALU_OUT=0x00FF -> RSP_DATA=0x00FF, RSP_TIMEOUT=0.
REQ-046 RST pulsed during WAIT -> no RSP_VALID and all outputs 0; then a simultaneous REQ0/REQ1 -> REQ0 granted first.
REQ-047 ALU_OUT_VALID pulsed during IDLE or ISSUE -> ignored; RSP_DATA unchanged.
